pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed-width, jump-only PC register. It adds a valid/ready handshake to fetch, 16/32-bit sequential increments, and prioritised trap and redirect inputs. A small return-address stack (RAS) predicts call and return targets. `pc_out` drives the instruction memory address; redirects come from execute, traps from the CSR/trap unit.

## Interface
Parameters:
- `ADDR_W`, 32, PC width in bits (≥ 16).
- `RESET_VECTOR`, `'0`, PC loaded on reset; must be 2-byte aligned (4-byte if `C_EXT`=0).
- `RAS_DEPTH`, 4, return-address stack entries; power of two, ≥ 2.
- `C_EXT`, 1, 1 enables 16-bit compressed increments and 2-byte alignment.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_ready`  in  1  fetch accepts `pc_out` this cycle.
- `pc_valid`  out  1  `pc_out` is a valid fetch address.
- `pc_out`  out  ADDR_W  current fetch PC.
- `is_compressed`  in  1  instruction at `pc_out` is 16-bit; ignored when `C_EXT`=0.
- `is_call`  in  1  predecoded call (JAL/JALR with rd = x1/x5) at `pc_out`.
- `is_ret`  in  1  predecoded return (JALR x0, rs1 = x1/x5) at `pc_out`.
- `call_target`  in  ADDR_W  predicted target of a call.
- `redirect_valid`  in  1  execute-stage mispredict or branch correction.
- `redirect_addr`  in  ADDR_W  corrected PC.
- `trap_valid`  in  1  trap or trap return.
- `trap_addr`  in  ADDR_W  trap vector or `mepc`.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries, for debug and verification.

## Operation
- **Accept.** An accept occurs when `pc_valid && fetch_ready`. `is_compressed`, `is_call`, `is_ret` and `call_target` are sampled only on accept.
- **Instruction length.** `len` = 2 if `C_EXT && is_compressed`, else 4. `seq` = `pc_out + len`, modulo 2^ADDR_W; wrap-around at the top is silent.
- **Next-PC priority**, highest first:
  - `rst`
  - `trap_valid`
  - `redirect_valid`
  - accept with `is_ret` and RAS non-empty: take the RAS top
  - accept with `is_call`: take `call_target`
  - other accept: take `seq`
  - no accept: hold `pc_out`
- **Alignment.** `trap_addr`, `redirect_addr` and `call_target` have bit 0 forced to 0. With `C_EXT`=0, bits [1:0] are forced to 0.
- **RAS push.** On an accepted `is_call`, push `seq`. The stack is circular: a push when full overwrites the oldest entry, and `ras_count` saturates at `RAS_DEPTH`.
- **RAS pop.** An accepted `is_ret` pops when `ras_count`>0. With an empty RAS it falls through to `seq` and `ras_count` stays 0.
- **Call and return together.** An accepted cycle with both `is_call` and `is_ret`: target = RAS top, then push `seq` into the same slot (pop+push). `ras_count` is unchanged. With an empty RAS: target = `call_target`, push `seq`.
- **Trap or redirect in an accept cycle.** The trap/redirect wins. RAS push/pop from that accept is suppressed and RAS contents are not restored or flushed.
- **Reset.** `pc_out`=`RESET_VECTOR`, `pc_valid`=0, `ras_count`=0, RAS pointer=0. RAS entry contents are don't-care.

## Timing
- `pc_out` and `pc_valid` are registered; the selected next PC appears on the cycle after the deciding edge.
- `pc_valid` rises on the first cycle after `rst` deasserts. It then stays 1, including across redirects and traps.
- Back-to-back accepts sustain one PC per cycle; there are no bubbles on sequential flow, calls or returns.
- Redirect/trap latency is 1 cycle: asserted in cycle N, `pc_out` = new address in N+1, regardless of `fetch_ready`.
- `rst` asserted mid-operation overrides all inputs in that cycle.
- While `fetch_ready`=0 with no trap/redirect, `pc_out` is stable (holds).

## Structure
- **Shared package** (`Types.v` / fetch package): `RESET_VECTOR` default, `INSN_LEN_16`/`INSN_LEN_32` constants, and the link-register indices x1/x5 used by predecode.
- **Sub-module `ras_stack`:** circular buffer holding pointer, count and entries, with `push`, `pop`, `top` and `count` ports, parametrised by `RAS_DEPTH` and `ADDR_W`.
- **Top level:** next-PC priority mux, alignment, and the `pc_out`/`pc_valid` registers.

## Test plan
- **Reset and sequential flow.** `RESET_VECTOR`=0x100, `rst` 1→0, `fetch_ready`=1, `is_compressed` pattern 0,1,1,0 → `pc_valid` rises on the first post-reset cycle. `pc_out` sequence is 0x100, 0x104, 0x106, 0x108, 0x10C.
- **Stall then redirect.** `fetch_ready`=0 for 3 cycles at `pc_out`=0x200 → `pc_out` holds 0x200. Then `redirect_valid`, `redirect_addr`=0x301 → next `pc_out`=0x300.
- **Trap beats redirect.** `trap_valid`=1 with `trap_addr`=0x80, same cycle as `redirect_valid`=1 with `redirect_addr`=0x400 and an accepted `is_call` → `pc_out`=0x80 and `ras_count` unchanged.
- **Call/return pair.** Call at 0x1000 (32-bit), `call_target`=0x2000 → `pc_out`=0x2000, `ras_count`=1. Return at 0x2010 → `pc_out`=0x1004, `ras_count`=0.
- **RAS overflow and underflow.** `RAS_DEPTH`=4, 5 nested calls → `ras_count`=4. 4 returns yield the 5th..2nd return addresses; the 5th return falls through to `seq` with `ras_count`=0.
- **Wrap and coroutine.** `pc_out`=0xFFFF_FFFC, 32-bit accept → `pc_out`=0x0. Simultaneous `is_call`+`is_ret` with RAS top 0x500 → `pc_out`=0x500, `ras_count` unchanged, new top = `seq`.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage constants: reset vector default, instruction lengths and
// the link-register indices that predecode uses to classify calls and returns.
package pc_gen_pkg;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSN_LEN_16 = 2;
  localparam int unsigned INSN_LEN_32 = 4;
  localparam logic [4:0]  LINK_REG_RA = 5'd1;
  localparam logic [4:0]  LINK_REG_T0 = 5'd5;
endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a simultaneous push and pop replaces the top entry in place.
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count
);
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx;

  // ptr_q addresses the next free slot, so the top lives one below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign count   = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push && !pop) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(RAS_DEPTH)) count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[pop ? top_idx : ptr_q] <= push_data;
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap > redirect > RAS return > call > sequential,
// with a registered PC and valid/ready handshake toward instruction fetch.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter bit                C_EXT        = 1'b1,
  localparam int unsigned      CNT_W        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              is_compressed,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  output logic [CNT_W-1:0]  ras_count
);
  // Handshake: a PC is consumed only when pc_valid && fetch_ready on a rising
  // edge; the predecode inputs are meaningful only in that cycle.
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-2){1'b1}}, (C_EXT ? 2'b10 : 2'b00)};

  logic              pc_valid_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              accept, flush, ras_nonempty;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] len, seq_pc, ras_top;
  logic [CNT_W-1:0]  ras_cnt;

  assign accept       = pc_valid_q && fetch_ready;
  assign flush        = trap_valid || redirect_valid;
  assign ras_nonempty = (ras_cnt != '0);
  assign len          = (C_EXT && is_compressed) ? ADDR_W'(INSN_LEN_16)
                                                 : ADDR_W'(INSN_LEN_32);
  assign seq_pc       = pc_q + len;

  // A trap or redirect in the same cycle discards the accept's RAS effect.
  assign ras_push = accept && !flush && is_call;
  assign ras_pop  = accept && !flush && is_ret && ras_nonempty;

  always_comb begin
    pc_d = pc_q;
    if (trap_valid)                          pc_d = trap_addr & ALIGN_MASK;
    else if (redirect_valid)                 pc_d = redirect_addr & ALIGN_MASK;
    else if (accept && is_ret && ras_nonempty) pc_d = ras_top;
    else if (accept && is_call)              pc_d = call_target & ALIGN_MASK;
    else if (accept)                         pc_d = seq_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  assign pc_out    = pc_q;
  assign pc_valid  = pc_valid_q;
  assign ras_count = ras_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequential flow, stalls, priorities,
// RAS call/return, overflow/underflow, wrap-around and coroutine swaps.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        pc_valid;
  logic [31:0] pc_out;
  logic        is_compressed, is_call, is_ret;
  logic [31:0] call_target;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0100),
    .RAS_DEPTH    (4),
    .C_EXT        (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_ready    (fetch_ready),
    .pc_valid       (pc_valid),
    .pc_out         (pc_out),
    .is_compressed  (is_compressed),
    .is_call        (is_call),
    .is_ret         (is_ret),
    .call_target    (call_target),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
    .trap_addr      (trap_addr),
    .ras_count      (ras_count)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    is_compressed  = 1'b0;
    is_call        = 1'b0;
    is_ret         = 1'b0;
    call_target    = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    trap_valid     = 1'b0;
    trap_addr      = '0;
  endtask

  task automatic drive_redirect(input logic [31:0] addr);
    clear_inputs();
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    fetch_ready = 1'b1;
    step();
    step();
    checks++;
    if (pc_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b expected 0", pc_valid);
    end
    checks++;
    if (pc_out !== 32'h100) begin
      errors++; $display("FAIL reset_pc: got %h expected 00000100", pc_out);
    end
    checks++;
    if (ras_count !== 3'd0) begin
      errors++; $display("FAIL reset_ras_count: got %0d expected 0", ras_count);
    end
    rst = 1'b0;
    step();
    checks++;
    if (pc_valid !== 1'b1 || pc_out !== 32'h100) begin
      errors++;
      $display("FAIL first_valid: got valid=%0b pc=%h expected valid=1 pc=00000100",
               pc_valid, pc_out);
    end
  endtask

  task automatic test_sequential();
    logic [3:0]  comp_pat;
    logic [31:0] exp_pc [4];
    comp_pat = 4'b0110;  // bit i is the compressed flag of accept i
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h106;
    exp_pc[2] = 32'h108; exp_pc[3] = 32'h10C;
    for (int i = 0; i < 4; i++) begin
      is_compressed = comp_pat[i];
      step();
      checks++;
      if (pc_out !== exp_pc[i] || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d: got pc=%h valid=%0b expected pc=%h valid=1",
                 i, pc_out, pc_valid, exp_pc[i]);
      end
    end
    is_compressed = 1'b0;
  endtask

  task automatic test_stall_redirect();
    drive_redirect(32'h200);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      is_compressed = 1'b1;
      is_call = 1'b1;
      call_target = 32'h900;
      step();
      checks++;
      if (pc_out !== 32'h200 || pc_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got pc=%h valid=%0b expected pc=00000200 valid=1",
                 i, pc_out, pc_valid);
      end
    end
    checks++;
    if (ras_count !== 3'd0) begin
      errors++; $display("FAIL stall_no_push: got %0d expected 0", ras_count);
    end
    clear_inputs();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h301;
    step();
    checks++;
    if (pc_out !== 32'h300) begin
      errors++; $display("FAIL redirect_align: got %h expected 00000300", pc_out);
    end
    clear_inputs();
    fetch_ready = 1'b1;
  endtask

  task automatic test_trap_priority();
    clear_inputs();
    is_call        = 1'b1;
    call_target    = 32'h999;
    trap_valid     = 1'b1;
    trap_addr      = 32'h81;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h400;
    step();
    checks++;
    if (pc_out !== 32'h80) begin
      errors++; $display("FAIL trap_wins: got %h expected 00000080", pc_out);
    end
    checks++;
    if (ras_count !== 3'd0) begin
      errors++; $display("FAIL trap_no_push: got %0d expected 0", ras_count);
    end
    clear_inputs();
    is_call        = 1'b1;
    call_target    = 32'h999;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h440;
    step();
    checks++;
    if (pc_out !== 32'h440 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL redirect_beats_call: got pc=%h cnt=%0d expected pc=00000440 cnt=0",
               pc_out, ras_count);
    end
    clear_inputs();
  endtask

  task automatic test_call_ret();
    drive_redirect(32'h1000);
    is_call = 1'b1;
    call_target = 32'h2000;
    step();
    checks++;
    if (pc_out !== 32'h2000 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL call: got pc=%h cnt=%0d expected pc=00002000 cnt=1", pc_out, ras_count);
    end
    drive_redirect(32'h2010);
    is_ret = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h1004 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL ret: got pc=%h cnt=%0d expected pc=00001004 cnt=0", pc_out, ras_count);
    end
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [5];
    logic [2:0]  exp_cnt [5];
    drive_redirect(32'h3000);
    // Five nested calls push 0x3004, 0x4004, 0x4104, 0x4204, 0x4304.
    for (int i = 0; i < 5; i++) begin
      is_call = 1'b1;
      call_target = 32'h4000 + 32'(i) * 32'h100;
      step();
    end
    is_call = 1'b0;
    checks++;
    if (pc_out !== 32'h4400 || ras_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: got pc=%h cnt=%0d expected pc=00004400 cnt=4", pc_out, ras_count);
    end
    exp_ret[0] = 32'h4304; exp_ret[1] = 32'h4204; exp_ret[2] = 32'h4104;
    exp_ret[3] = 32'h4004; exp_ret[4] = 32'h4008;
    exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd1;
    exp_cnt[3] = 3'd0; exp_cnt[4] = 3'd0;
    for (int i = 0; i < 5; i++) begin
      is_ret = 1'b1;
      step();
      checks++;
      if (pc_out !== exp_ret[i] || ras_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL ret_%0d: got pc=%h cnt=%0d expected pc=%h cnt=%0d",
                 i, pc_out, ras_count, exp_ret[i], exp_cnt[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrap_coroutine();
    drive_redirect(32'hFFFF_FFFC);
    step();
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL wrap: got %h expected 00000000", pc_out);
    end
    drive_redirect(32'h4FC);
    is_call = 1'b1;
    call_target = 32'h600;
    step();
    is_ret = 1'b1;
    call_target = 32'h700;
    step();
    checks++;
    if (pc_out !== 32'h500 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL coroutine: got pc=%h cnt=%0d expected pc=00000500 cnt=1", pc_out, ras_count);
    end
    clear_inputs();
    is_ret = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h604 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL coroutine_top: got pc=%h cnt=%0d expected pc=00000604 cnt=0",
               pc_out, ras_count);
    end
    is_call = 1'b1;
    call_target = 32'h800;
    step();
    checks++;
    if (pc_out !== 32'h800 || ras_count !== 3'd1) begin
      errors++;
      $display("FAIL coroutine_empty: got pc=%h cnt=%0d expected pc=00000800 cnt=1",
               pc_out, ras_count);
    end
    is_call = 1'b0;
    step();
    checks++;
    if (pc_out !== 32'h608 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL coroutine_empty_ret: got pc=%h cnt=%0d expected pc=00000608 cnt=0",
               pc_out, ras_count);
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    is_call = 1'b1;
    call_target = 32'hA00;
    step();
    trap_valid = 1'b1;
    trap_addr = 32'h80;
    rst = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h100 || pc_valid !== 1'b0 || ras_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got pc=%h valid=%0b cnt=%0d expected pc=00000100 valid=0 cnt=0",
               pc_out, pc_valid, ras_count);
    end
    rst = 1'b0;
    clear_inputs();
    step();
    checks++;
    if (pc_out !== 32'h100 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got pc=%h valid=%0b expected pc=00000100 valid=1",
               pc_out, pc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_trap_priority();
    test_call_ret();
    test_ras_overflow();
    test_wrap_coroutine();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
